seed_packer: RTL and testbench
==============================

SEED_PACKER -- requirements
Module: seed_packer

Interface
REQ-001 Parameter WIDTH, default 256, meaning: bits per packed word, equal to the downstream queue word width.
REQ-002 Port clk  input  1  single system clock; all logic on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port inter_fail  input  1  intermittent health-test failure; flushes the partial word.
REQ-005 Port perm_fail  input  1  permanent health-test failure; halts the block until rst.
REQ-006 Port bit_in  input  1  raw entropy bit.
REQ-007 Port bit_valid  input  1  bit_in qualifier; one bit per asserted cycle.
REQ-008 Port fifo_full  input  1  downstream queue full flag.
REQ-009 Port fifo_enque  output  1  enqueue strobe to the downstream queue.
REQ-010 Port fifo_wdata  output  WIDTH  packed word to the downstream queue.
REQ-011 Port fill_level  output  $clog2(WIDTH)+1  bits accepted into the current word.
REQ-012 Port halted  output  1  high while in state HALT.

Function
REQ-013 The block SHALL implement three states: FILL, HOLD and HALT.
REQ-014 In FILL, each cycle with bit_valid=1 SHALL shift the word left, load bit_in into bit 0 and increment fill_level.
REQ-015 The first accepted bit of a word SHALL therefore appear at fifo_wdata[WIDTH-1].
REQ-016 When bit WIDTH is accepted, the block SHALL enter HOLD on the next cycle with fill_level=WIDTH.
REQ-017 In HOLD, fifo_enque SHALL equal !fifo_full, combinationally, and fifo_wdata SHALL hold the complete word.
REQ-018 Latency: with fifo_full=0, fifo_enque SHALL assert in the cycle after the last bit is accepted.
REQ-019 fifo_enque SHALL be high for exactly one cycle per word.
REQ-020 After the enqueue cycle, the block SHALL return to FILL with fill_level=0 and the word cleared.
REQ-021 Bits presented in HOLD, including the enqueue cycle, SHALL be dropped.
REQ-022 While fifo_full=1 in HOLD, the block SHALL stall indefinitely with the word unchanged.
REQ-023 fifo_enque SHALL be 0 in FILL, in HALT, and in any cycle where rst, inter_fail or perm_fail is high.
REQ-024 inter_fail=1 SHALL, on the next edge, clear the word, set fill_level=0 and enter FILL from FILL or HOLD, discarding any held word.
REQ-025 perm_fail=1 SHALL, on the next edge, clear the word, set fill_level=0 and enter HALT from any state.
REQ-026 HALT SHALL be left only by rst, and halted SHALL be 1 in HALT.
REQ-027 Input priority SHALL be rst > perm_fail > inter_fail > normal operation.
REQ-028 A bit_valid arriving together with inter_fail or perm_fail SHALL be dropped.
REQ-029 fill_level SHALL never exceed WIDTH.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL set: state FILL, word 0, fill_level 0, halted 0, fifo_enque 0, fifo_wdata all zero.
REQ-031 Reset SHALL take effect mid-word or mid-stall, discarding all partial and held data.

Configuration
REQ-032 Macro SEED_PACKER_DROP_CNT_EN, when defined, SHALL add output drop_cnt (16 bits).
REQ-033 drop_cnt SHALL count the bits dropped in HOLD, saturate at 16'hFFFF, and clear only on rst.
REQ-034 Without SEED_PACKER_DROP_CNT_EN, the port and its counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-035 WIDTH=256, fifo_full=0, 256 consecutive valid bits of pattern 1,0,1,0... -> fifo_enque one cycle after the last bit; fifo_wdata=256'hAAAA...AA; fill_level returns to 0.
REQ-036 Word complete with fifo_full=1 for 10 cycles while bit_valid=1 -> fifo_enque=0 for those 10 cycles, word held, enqueue in the cycle fifo_full drops, 11 bits dropped (drop_cnt=11 when SEED_PACKER_DROP_CNT_EN is defined).
REQ-037 100 bits accepted, then inter_fail pulsed for 1 cycle -> fill_level=0, no enqueue; the next 256 bits produce exactly one word containing only post-fail bits.
REQ-038 perm_fail pulsed during HOLD -> halted=1, fifo_enque stays 0 despite bit_valid; rst -> halted=0, fill_level=0.
REQ-039 rst, perm_fail and bit_valid asserted in the same cycle -> post-edge state FILL, halted=0, fill_level=0.

Source files
------------

// File: rtl/seed_packer.sv
// Entropy bit packer: shifts raw bits into WIDTH-bit words and hands full words to a queue.
// Optional feature macro SEED_PACKER_DROP_CNT_EN adds a saturating count of bits dropped while holding.
module seed_packer #(
   parameter int WIDTH = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inter_fail,
   input  logic                     perm_fail,
   input  logic                     bit_in,
   input  logic                     bit_valid,
   input  logic                     fifo_full,
   output logic                     fifo_enque,
   output logic [WIDTH-1:0]         fifo_wdata,
   output logic [$clog2(WIDTH):0]   fill_level,
`ifdef SEED_PACKER_DROP_CNT_EN
   output logic [15:0]              drop_cnt,
`endif
   output logic                     halted
);

   localparam int FW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             enque_d;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      fill_d  = fill_q;
      // The queue sees the enqueue in the same cycle it deasserts full.
      enque_d = (state_q == HOLD) && !fifo_full && !rst && !inter_fail && !perm_fail;
      if (perm_fail) begin
         state_d = HALT;
         word_d  = '0;
         fill_d  = '0;
      end else if (state_q != HALT) begin
         if (inter_fail) begin
            state_d = FILL;
            word_d  = '0;
            fill_d  = '0;
         end else begin
            case (state_q)
               FILL: begin
                  if (bit_valid) begin
                     word_d = {word_q[WIDTH-2:0], bit_in};
                     fill_d = fill_q + 1'b1;
                     if (fill_q == FW'(WIDTH - 1)) begin
                        state_d = HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (!fifo_full) begin
                     state_d = FILL;
                     word_d  = '0;
                     fill_d  = '0;
                  end
               end
               default: begin
                  state_d = state_q;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         word_q  <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         fill_q  <= fill_d;
      end
   end

   assign fifo_enque = enque_d;
   assign fifo_wdata = word_q;
   assign fill_level = fill_q;
   assign halted     = (state_q == HALT);

`ifdef SEED_PACKER_DROP_CNT_EN
   logic [15:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if ((state_q == HOLD) && bit_valid && !inter_fail && !perm_fail && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_seed_packer.sv
// Bench for seed_packer: directed scenarios with literal expectations plus a long random run,
// all checked every cycle against a queue-based model of the accepted bits.
module tb_seed_packer;

   localparam int W = 256;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           inter_fail = 1'b0;
   logic           perm_fail = 1'b0;
   logic           bit_in = 1'b0;
   logic           bit_valid = 1'b0;
   logic           fifo_full = 1'b0;
   logic           fifo_enque;
   logic [W-1:0]   fifo_wdata;
   logic [8:0]     fill_level;
   logic           halted;
`ifdef SEED_PACKER_DROP_CNT_EN
   logic [15:0]    drop_cnt;
`endif

   seed_packer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .inter_fail (inter_fail),
      .perm_fail  (perm_fail),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .fifo_full  (fifo_full),
      .fifo_enque (fifo_enque),
      .fifo_wdata (fifo_wdata),
      .fill_level (fill_level),
`ifdef SEED_PACKER_DROP_CNT_EN
      .drop_cnt   (drop_cnt),
`endif
      .halted     (halted)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int enq_count = 0;

   // Model: mode 0 = filling, 1 = holding a full word, 2 = halted.
   int  m_mode = 0;
   bit  m_q[$];
   int  m_drops = 0;
   bit  chk_en = 1'b0;

   logic           obs_enq;
   logic [W-1:0]   obs_w;
   logic [8:0]     obs_fill;
   logic           obs_halt;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pack_model();
      logic [W-1:0] w = '0;
      foreach (m_q[i]) w = (w << 1) | W'(m_q[i]);
      return w;
   endfunction

   // Model update on each rising edge from the inputs held during the cycle.
   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_mode = 0;
            m_q.delete();
            m_drops = 0;
            chk_en = 1'b1;
         end else if (perm_fail) begin
            m_mode = 2;
            m_q.delete();
         end else if (m_mode == 2) begin
            m_mode = 2;
         end else if (inter_fail) begin
            m_mode = 0;
            m_q.delete();
         end else if (m_mode == 0) begin
            if (bit_valid) begin
               m_q.push_back(bit_in);
               if (m_q.size() == W) m_mode = 1;
            end
         end else begin
            if (bit_valid && m_drops < 65535) m_drops++;
            if (!fifo_full) begin
               m_mode = 0;
               m_q.delete();
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("enque", W'(fifo_enque),
                  W'((m_mode == 1) && !fifo_full && !rst && !inter_fail && !perm_fail));
            check("wdata", fifo_wdata, pack_model());
            check("fill_level", W'(fill_level), W'(m_q.size()));
            check("halted", W'(halted), W'(m_mode == 2));
`ifdef SEED_PACKER_DROP_CNT_EN
            check("drop_cnt", W'(drop_cnt), W'(m_drops));
`endif
            if (fifo_enque === 1'b1) enq_count++;
         end
      end
   end

   task automatic step(input logic v, input logic b, input logic full,
                       input logic inf, input logic pf, input logic r);
      bit_valid  = v;
      bit_in     = b;
      fifo_full  = full;
      inter_fail = inf;
      perm_fail  = pf;
      rst        = r;
      @(negedge clk);
      obs_enq  = fifo_enque;
      obs_w    = fifo_wdata;
      obs_fill = fill_level;
      obs_halt = halted;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] alt;
      logic [W-1:0] w;
      logic         b;
      int           e0;
      alt = {128{2'b10}};

      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      check("reset_fill", W'(fill_level), '0);
      check("reset_halted", W'(halted), '0);
      check("reset_wdata", fifo_wdata, '0);
      check("reset_enque", W'(fifo_enque), '0);

      // Alternating pattern, first bit lands in the MSB.
      for (int i = 0; i < W; i++) step(1, (i % 2 == 0), 0, 0, 0, 0);
      check("alt_last_fill_no_enq", W'(obs_enq), '0);
      step(0, 0, 0, 0, 0, 0);
      check("alt_enq", W'(obs_enq), W'(1));
      check("alt_word", obs_w, alt);
      check("alt_fill_full", W'(obs_fill), W'(W));
      check("alt_fill_zero", W'(fill_level), '0);
      check("alt_word_cleared", fifo_wdata, '0);

      // Back-pressure: 10 stalled cycles plus the enqueue cycle, all with bits offered.
      step(0, 0, 0, 0, 0, 1);
      w = '0;
      for (int i = 0; i < W; i++) begin
         b = 1'($urandom_range(0, 1));
         w = {w[W-2:0], b};
         step(1, b, 0, 0, 0, 0);
      end
      for (int k = 0; k < 10; k++) begin
         step(1, 1, 1, 0, 0, 0);
         check("stall_no_enq", W'(obs_enq), '0);
         check("stall_word", obs_w, w);
      end
      step(1, 1, 0, 0, 0, 0);
      check("stall_release_enq", W'(obs_enq), W'(1));
      check("stall_release_word", obs_w, w);
      check("stall_after_fill", W'(fill_level), '0);
`ifdef SEED_PACKER_DROP_CNT_EN
      check("stall_drop_cnt", W'(drop_cnt), W'(11));
`endif

      // Intermittent failure mid-word discards the partial word.
      for (int i = 0; i < 100; i++) step(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      check("pre_fail_fill", W'(fill_level), W'(100));
      step(1, 1, 0, 1, 0, 0);
      check("inter_no_enq", W'(obs_enq), '0);
      check("inter_fill_zero", W'(fill_level), '0);
      e0 = enq_count;
      w = '0;
      for (int i = 0; i < W; i++) begin
         b = 1'($urandom_range(0, 1));
         w = {w[W-2:0], b};
         step(1, b, 0, 0, 0, 0);
      end
      step(0, 0, 0, 0, 0, 0);
      check("inter_next_word", obs_w, w);
      check("inter_one_enq", W'(enq_count - e0), W'(1));

      // Permanent failure while holding.
      for (int i = 0; i < W; i++) step(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0);
      check("perm_no_enq", W'(obs_enq), '0);
      check("perm_halted", W'(halted), W'(1));
      for (int i = 0; i < 20; i++) begin
         step(1, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
         check("halt_no_enq", W'(obs_enq), '0);
         check("halt_stays", W'(obs_halt), W'(1));
      end
      step(0, 0, 0, 0, 0, 1);
      check("rst_unhalts", W'(halted), '0);
      check("rst_fill_zero", W'(fill_level), '0);

      // Reset wins over perm_fail and bit_valid in the same cycle.
      for (int i = 0; i < 50; i++) step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 1);
      check("prio_halted", W'(halted), '0);
      check("prio_fill", W'(fill_level), '0);

      // Random run; the per-cycle checker covers it.
      for (int c = 0; c < 6000; c++) begin
         logic r;
         r = ($urandom_range(0, 999) == 0) || (halted && $urandom_range(0, 39) == 0);
         step($urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 30,
              $urandom_range(0, 599) == 0, $urandom_range(0, 2499) == 0, r);
      end
      check("random_words_seen", W'(enq_count > 10), W'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
